key_flap_debounce: RTL and testbench

Debounce and pulse-shaping stage directly downstream of the 2-flop key synchronizer. Takes the synchronized key level, filters contact bounce with a saturating-count FSM, and emits a debounced level plus a single-cycle `flap` pulse for the bird physics block. Optionally auto-repeats `flap` while the key is held.

---
 rtl/flappy_pkg.sv | 18 +
 rtl/key_flap_debounce.sv | 138 +++++++++++++
 tb/tb_key_flap_debounce.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
// Shared types and constants for the flappy game blocks.
//   key_state_t : debounce FSM states used by key_flap_debounce
//   CLK_HZ      : system clock frequency, for deriving cycle-count parameters
// -----------------------------------------------------------------------------
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;

    localparam int CLK_HZ = 50_000_000;

endpackage : flappy_pkg

// File: rtl/key_flap_debounce.sv
// -----------------------------------------------------------------------------
// key_flap_debounce
// Filters contact bounce on the synchronized key level and produces a
// debounced level plus a one-cycle flap pulse, with optional auto-repeat
// while the key is held.
//
// Parameters
//   DEBOUNCE_CYCLES : stable samples (beyond the first) needed to accept a
//                     press or release; >= 2
//   REPEAT_CYCLES   : auto-repeat period while held; 0 disables repeat, else >= 2
// Ports
//   clock    in  system clock, rising edge
//   reset_n  in  synchronous active-low reset
//   key_sync in  synchronized key level, 1 = pressed
//   enable   in  game-running qualifier, gates flap only
//   pressed  out debounced key level (registered)
//   flap     out one-cycle press / repeat pulse (registered)
// -----------------------------------------------------------------------------
module key_flap_debounce
    import flappy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_sync,
    input  logic enable,
    output logic pressed,
    output logic flap
);

    // Counter widths are $clog2 of the parameter, never less than one bit
    // so a disabled repeat counter still has a legal declaration.
    localparam int DW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int RW = ($clog2(REPEAT_CYCLES)   < 1) ? 1 : $clog2(REPEAT_CYCLES);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = (REPEAT_CYCLES == 0) ? '0 : RW'(REPEAT_CYCLES - 1);

    key_state_t    r_state;
    logic [DW-1:0] r_dcnt;
    logic [RW-1:0] r_rcnt;
    logic          r_pressed;
    logic          r_flap;

    key_state_t    w_state_nxt;
    logic [DW-1:0] w_dcnt_nxt;
    logic [RW-1:0] w_rcnt_nxt;
    logic          w_pressed_nxt;
    logic          w_flap_nxt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_dcnt    <= '0;
            r_rcnt    <= '0;
            r_pressed <= 1'b0;
            r_flap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_pressed <= w_pressed_nxt;
            r_flap    <= w_flap_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_rcnt_nxt  = r_rcnt;
        w_flap_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (key_sync) begin
                    w_state_nxt = PRESS_WAIT;
                    w_dcnt_nxt  = '0;
                end
            end

            PRESS_WAIT: begin
                if (!key_sync) begin
                    // Bounce: drop back without a pulse.
                    w_state_nxt = IDLE;
                end else if (r_dcnt == D_LAST) begin
                    w_state_nxt = HELD;
                    w_flap_nxt  = enable;
                    w_rcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end

            HELD: begin
                if (!key_sync) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_dcnt_nxt  = '0;
                end else if (REPEAT_CYCLES != 0) begin
                    if (r_rcnt == R_LAST) begin
                        w_flap_nxt = enable;
                        w_rcnt_nxt = '0;
                    end else begin
                        w_rcnt_nxt = r_rcnt + 1'b1;
                    end
                end
            end

            RELEASE_WAIT: begin
                if (key_sync) begin
                    // Release glitch rejected; repeat phase restarts.
                    w_state_nxt = HELD;
                    w_rcnt_nxt  = '0;
                end else if (r_dcnt == D_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // The debounced level is registered alongside the state it reflects.
        w_pressed_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);
    end

    assign pressed = r_pressed;
    assign flap    = r_flap;

endmodule : key_flap_debounce

// File: tb/tb_key_flap_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_flap_debounce
// Drives two instances (REPEAT_CYCLES=6 and REPEAT_CYCLES=0, both with
// DEBOUNCE_CYCLES=4) from the same stimulus. A run-length reference model
// predicts {pressed, flap} per cycle into a queue; a negedge monitor pops
// and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_key_flap_debounce;

    localparam int D  = 4;
    localparam int R6 = 6;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic key_sync = 1'b0;
    logic enable = 1'b1;

    logic pressed6, flap6, pressed0, flap0;

    always #5 clock = ~clock;

    key_flap_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R6)) dut6 (
        .clock   (clock),
        .reset_n (reset_n),
        .key_sync(key_sync),
        .enable  (enable),
        .pressed (pressed6),
        .flap    (flap6)
    );

    key_flap_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .key_sync(key_sync),
        .enable  (enable),
        .pressed (pressed0),
        .flap    (flap0)
    );

    // Reference model: counts consecutive samples disagreeing with the
    // debounced level; D+1 of them flips the level. While pressed, the
    // repeat phase counts high samples since the last acceptance or
    // since the key came back from a rejected release glitch.
    typedef struct {
        bit pressed;
        int run;
        int hold;
    } model_t;

    model_t m6, m0;

    int n_cmp = 0;
    int n_bad = 0;
    int flaps6 = 0;
    int flaps0 = 0;

    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(inout model_t s, input bit k, input bit e,
                                       input bit rst_n, input int rep, output bit fl);
        fl = 1'b0;
        if (!rst_n) begin
            s.pressed = 1'b0;
            s.run     = 0;
            s.hold    = 0;
        end else if (k != s.pressed) begin
            s.run++;
            if (s.run == D + 1) begin
                s.pressed = k;
                s.run     = 0;
                s.hold    = 0;
                if (k) fl = e;
            end
        end else begin
            if (s.pressed) begin
                if (s.run > 0) begin
                    s.hold = 0;
                end else begin
                    s.hold++;
                    if (rep != 0 && (s.hold % rep) == 0) fl = e;
                end
            end
            s.run = 0;
        end
    endfunction

    // One clock of stimulus: apply inputs, let the edge happen, predict.
    task automatic step(input bit k, input bit e, input bit rst_n);
        bit f6, f0;
        key_sync = k;
        enable   = e;
        reset_n  = rst_n;
        @(posedge clock);
        model_step(m6, k, e, rst_n, R6, f6);
        model_step(m0, k, e, rst_n, 0, f0);
        exp_q.push_back({m6.pressed, f6, m0.pressed, f0});
        #1;
    endtask

    task automatic run(input bit k, input bit e, input int n);
        for (int i = 0; i < n; i++) step(k, e, 1'b1);
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    // Monitor: outputs are valid every cycle, compared at the falling edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [3:0] exp;
            exp = exp_q.pop_front();
            check("outs{p6,f6,p0,f0}", {pressed6, flap6, pressed0, flap0}, exp);
            if (flap6 === 1'b1) flaps6++;
            if (flap0 === 1'b1) flaps0++;
        end
    end

    initial begin
        int base6, base0;
        int bounce[8] = '{1, 1, 0, 1, 1, 1, 0, 0};

        m6 = '{default: 0};
        m0 = '{default: 0};

        // Reset, then a 20-cycle press.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        settle();
        base6 = flaps6;
        base0 = flaps0;
        run(1'b1, 1'b1, 20);
        settle();
        check("flaps_r6_20high", flaps6 - base6, 3);
        check("flaps_r0_20high", flaps0 - base0, 1);

        // Release glitch 0,0,1 keeps pressed; then full release.
        run(1'b0, 1'b1, 2);
        run(1'b1, 1'b1, 8);
        run(1'b0, 1'b1, 6);

        // Bounce pattern never reaches acceptance.
        settle();
        base6 = flaps6;
        for (int i = 0; i < 8; i++) step(bounce[i][0], 1'b1, 1'b1);
        settle();
        check("flaps_bounce", flaps6 - base6, 0);

        // enable low through press and hold, raised mid-hold.
        run(1'b1, 1'b0, 20);
        run(1'b1, 1'b1, 10);
        run(1'b0, 1'b1, 6);

        // Reset at the 3rd high sample while key stays high.
        run(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 1'b0);
        run(1'b1, 1'b1, 8);
        run(1'b0, 1'b1, 6);

        // Long hold on the non-repeating build: exactly one flap.
        settle();
        base0 = flaps0;
        run(1'b1, 1'b1, 50);
        settle();
        check("flaps_r0_50high", flaps0 - base0, 1);
        run(1'b0, 1'b1, 6);

        // Randomized runs of key levels, enable and occasional reset.
        for (int seg = 0; seg < 120; seg++) begin
            bit lvl;
            bit en;
            int len;
            lvl = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 40) == 0) step(lvl, en, 1'b0);
            else run(lvl, en, len);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_key_flap_debounce
